// File: rtl/uart_loop_ctrl_pkg.sv
// Shared definitions for the UART loopback slice: data width, default clock and
// baud constants shared with uart_rx/uart_tx, and the sequencer state encoding.
package uart_loop_ctrl_pkg;

    localparam int UART_DATA_W = 8;
    localparam int CLK_FREQ    = 50_000_000;
    localparam int UART_BPS    = 115_200;

    // Sequencer states, 3-bit binary encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4
    } ctrl_state_e;

    // Clock cycles per UART bit, used by uart_rx/uart_tx for their bit timers.
    function automatic int baud_div(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_loop_ctrl_if.sv
// Handshake bundle between the loopback sequencer and its neighbours
// (uart_rx on the write side, uart_tx on the read side, status to the host).
interface uart_loop_ctrl_if #(
    parameter int AW = 4
);
    import uart_loop_ctrl_pkg::*;

    logic                   rx_done;
    logic [UART_DATA_W-1:0] rx_data;
    logic                   tx_busy;
    logic                   tx_en;
    logic [UART_DATA_W-1:0] tx_data;
    logic [AW:0]            fifo_level;
    logic                   overflow;
    logic                   ovf_clr;
    logic                   tx_err;

    // Sequencer side.
    modport slave (
        input  rx_done, rx_data, tx_busy, ovf_clr,
        output tx_en, tx_data, fifo_level, overflow, tx_err
    );

    // Environment side (receiver, transmitter, host).
    modport master (
        output rx_done, rx_data, tx_busy, ovf_clr,
        input  tx_en, tx_data, fifo_level, overflow, tx_err
    );

endinterface

// File: rtl/uart_loop_ctrl_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO. Pointers carry one extra wrap
// bit so full and empty are distinguishable without a separate counter.
module uart_loop_ctrl_byte_fifo
    import uart_loop_ctrl_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = UART_DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q,  level_d;
    logic          wr_ok_s;
    logic          rd_ok_s;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign level   = level_q;

    // A read frees the head slot in the same cycle, so a write into a full
    // FIFO is accepted when it coincides with a read.
    assign rd_ok_s = rd_en && !empty;
    assign wr_ok_s = wr_en && (!full || rd_ok_s);

    // Next pointer and occupancy values.
    always_comb begin
        if (wr_ok_s) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_ok_s) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        level_d = wr_ptr_d - rd_ptr_d;
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care while empty, so it has no reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_loop_ctrl.sv
// Loopback sequencer: buffers bytes from uart_rx and replays them to uart_tx
// one frame at a time, retrying a start strobe that uart_tx never acknowledges.
module uart_loop_ctrl
    import uart_loop_ctrl_pkg::*;
#(
    parameter int FIFO_AW   = 4,
    parameter int BUSY_TMO  = 63,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_loop_ctrl_if.slave   bus
);

    localparam int TMO_W = $clog2(BUSY_TMO + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    ctrl_state_e            state_q,     state_d;
    logic [UART_DATA_W-1:0] tx_data_q,   tx_data_d;
    logic                   tx_en_q,     tx_en_d;
    logic                   tx_err_q,    tx_err_d;
    logic                   overflow_q,  overflow_d;
    logic [TMO_W-1:0]       tmo_cnt_q,   tmo_cnt_d;
    logic [RTY_W-1:0]       retry_cnt_q, retry_cnt_d;
    logic [TMO_W-1:0]       tmo_inc_s;

    logic                   fifo_wr_en_s;
    logic                   fifo_rd_en_s;
    logic [UART_DATA_W-1:0] fifo_head_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [FIFO_AW:0]       fifo_level_s;
    logic                   ovf_event_s;

    // Pop happens exactly in LOAD, where the FIFO is known to be non-empty.
    assign fifo_rd_en_s = (state_q == ST_LOAD);
    assign fifo_wr_en_s = bus.rx_done && (!fifo_full_s || fifo_rd_en_s);
    assign ovf_event_s  = bus.rx_done && fifo_full_s && !fifo_rd_en_s;

    uart_loop_ctrl_byte_fifo #(
        .AW (FIFO_AW),
        .DW (UART_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr_en_s),
        .wr_data (bus.rx_data),
        .rd_en   (fifo_rd_en_s),
        .rd_data (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level_s)
    );

    // Sequencer next-state, start strobe, timeout and retry bookkeeping.
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_en_d     = 1'b0;
        tx_err_d    = 1'b0;
        tmo_cnt_d   = tmo_cnt_q;
        retry_cnt_d = retry_cnt_q;
        tmo_inc_s   = tmo_cnt_q + TMO_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s && !bus.tx_busy) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // tx_en is registered, so it is raised here to be high in START.
                tx_data_d = fifo_head_s;
                tmo_cnt_d = '0;
                tx_en_d   = 1'b1;
                state_d   = ST_START;
            end
            ST_START: begin
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (bus.tx_busy) begin
                    retry_cnt_d = '0;
                    state_d     = ST_WAIT_LO;
                end else if (tmo_inc_s == TMO_W'(BUSY_TMO)) begin
                    tmo_cnt_d = '0;
                    if (retry_cnt_q < RTY_W'(MAX_RETRY)) begin
                        retry_cnt_d = retry_cnt_q + RTY_W'(1);
                        tx_en_d     = 1'b1;
                        state_d     = ST_START;
                    end else begin
                        retry_cnt_d = '0;
                        tx_err_d    = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else begin
                    tmo_cnt_d = tmo_inc_s;
                end
            end
            ST_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_LO;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky overflow: a new drop event takes priority over a clear.
    always_comb begin
        if (ovf_event_s) begin
            overflow_d = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tx_data_q   <= '0;
            tx_en_q     <= 1'b0;
            tx_err_q    <= 1'b0;
            overflow_q  <= 1'b0;
            tmo_cnt_q   <= '0;
            retry_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_en_q     <= tx_en_d;
            tx_err_q    <= tx_err_d;
            overflow_q  <= overflow_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

    assign bus.tx_en      = tx_en_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_err     = tx_err_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_level = fifo_level_s;

endmodule
